// File: rtl/spi_cmd_sched.sv
// spi_cmd_sched: buffers 16-bit motor-speed commands and launches one SPI
// frame per word on the shift stage. It keeps a minimum gap between frames,
// re-sends the last word after a quiet period, and flags a missing
// acknowledge as a sticky timeout.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for a queued word or for the refresh interval
// START     | spi_start high, waiting for the shift stage to leave idle
// WAIT_DONE | frame in progress, waiting for spi_ready to return high
// GAP       | enforced idle time before the next frame may start
module spi_cmd_sched #(
    parameter int          FIFO_DEPTH     = 4,
    parameter logic [7:0]  GAP_CYCLES     = 8'd4,
    parameter logic [7:0]  ACK_TIMEOUT    = 8'd32,
    parameter logic [15:0] REFRESH_CYCLES = 16'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    input  logic [15:0] cmd_data,
    output logic        cmd_ready,
    input  logic        spi_ready,
    output logic        spi_start,
    output logic [15:0] spi_data,
    input  logic        err_clr,
    output logic        err_timeout,
    output logic        busy,
    output logic [4:0]  fifo_level,
    output logic [15:0] frames_sent
);
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, WAIT_DONE, GAP} state_t;

    state_t        state, state_nx;
    logic [15:0]   mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [4:0]    count;
    logic [15:0]   last_word, last_word_nx;
    logic [15:0]   spi_data_nx, frames_nx;
    logic [15:0]   refresh_cnt, refresh_nx;
    logic [7:0]    ack_cnt, ack_nx;
    logic [7:0]    gap_cnt, gap_nx;
    logic          spi_start_nx;
    logic          sent_any, sent_any_nx;
    logic          err_set;
    logic          push, pop;

    assign cmd_ready  = (count != 5'(FIFO_DEPTH));
    assign push       = cmd_valid & cmd_ready & ~rst;
    assign fifo_level = count;
    assign busy       = (state != IDLE);

    // Next-state, frame launch and counter updates.
    always_comb begin
        state_nx     = state;
        spi_start_nx = spi_start;
        spi_data_nx  = spi_data;
        last_word_nx = last_word;
        frames_nx    = frames_sent;
        refresh_nx   = refresh_cnt;
        ack_nx       = ack_cnt;
        gap_nx       = gap_cnt;
        sent_any_nx  = sent_any;
        err_set      = 1'b0;
        pop          = 1'b0;
        case (state)
            IDLE: begin
                if (count != 5'd0) begin
                    pop          = 1'b1;
                    spi_data_nx  = mem[rd_ptr];
                    last_word_nx = mem[rd_ptr];
                    spi_start_nx = 1'b1;
                    ack_nx       = 8'd0;
                    refresh_nx   = 16'd0;
                    state_nx     = START;
                end else if ((REFRESH_CYCLES != 16'd0) && sent_any &&
                             (refresh_cnt == REFRESH_CYCLES - 16'd1)) begin
                    spi_data_nx  = last_word;
                    spi_start_nx = 1'b1;
                    ack_nx       = 8'd0;
                    // restart the interval so an aborted refresh does not retrigger at once
                    refresh_nx   = 16'd0;
                    state_nx     = START;
                end else begin
                    refresh_nx = refresh_cnt + 16'd1;
                end
            end
            START: begin
                if (!spi_ready) begin
                    spi_start_nx = 1'b0;
                    state_nx     = WAIT_DONE;
                end else if (ack_cnt == ACK_TIMEOUT - 8'd1) begin
                    spi_start_nx = 1'b0;
                    err_set      = 1'b1;
                    gap_nx       = 8'd0;
                    state_nx     = (GAP_CYCLES == 8'd0) ? IDLE : GAP;
                end else begin
                    ack_nx = ack_cnt + 8'd1;
                end
            end
            WAIT_DONE: begin
                if (spi_ready) begin
                    frames_nx   = frames_sent + 16'd1;
                    refresh_nx  = 16'd0;
                    sent_any_nx = 1'b1;
                    gap_nx      = 8'd0;
                    state_nx    = (GAP_CYCLES == 8'd0) ? IDLE : GAP;
                end
            end
            GAP: begin
                if (gap_cnt == GAP_CYCLES - 8'd1) state_nx = IDLE;
                else                              gap_nx   = gap_cnt + 8'd1;
            end
            default: state_nx = IDLE;
        endcase
        if (count != 5'd0) refresh_nx = 16'd0;
    end

    // State, datapath and FIFO bookkeeping registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            spi_start   <= 1'b0;
            spi_data    <= 16'd0;
            last_word   <= 16'd0;
            frames_sent <= 16'd0;
            refresh_cnt <= 16'd0;
            ack_cnt     <= 8'd0;
            gap_cnt     <= 8'd0;
            sent_any    <= 1'b0;
            err_timeout <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= 5'd0;
        end else begin
            state       <= state_nx;
            spi_start   <= spi_start_nx;
            spi_data    <= spi_data_nx;
            last_word   <= last_word_nx;
            frames_sent <= frames_nx;
            refresh_cnt <= refresh_nx;
            ack_cnt     <= ack_nx;
            gap_cnt     <= gap_nx;
            sent_any    <= sent_any_nx;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + 5'd1;
                2'b01:   count <= count - 5'd1;
                default: count <= count;
            endcase
            if (err_set)      err_timeout <= 1'b1;
            else if (err_clr) err_timeout <= 1'b0;
        end
    end

    // FIFO storage; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= cmd_data;
    end
endmodule

// File: tb/tb_spi_cmd_sched.sv
// Bench for spi_cmd_sched: shift-stage model, timestamp-based scheduler model
// checked every cycle, and directed scenarios with literal expectations.
module tb_spi_cmd_sched;
    localparam int          DEPTH = 4;
    localparam logic [7:0]  GAP   = 8'd4;
    localparam logic [7:0]  ACK   = 8'd32;
    localparam logic [15:0] REF   = 16'd100;

    logic        clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0, err_clr = 1'b0;
    logic [15:0] cmd_data = 16'd0;
    logic        cmd_ready, spi_start, err_timeout, busy;
    logic [15:0] spi_data, frames_sent;
    logic [4:0]  fifo_level;
    logic        spi_ready = 1'b1;
    bit          tie_high = 1'b0;

    int errors = 0, checks = 0, edge_n = 0;

    spi_cmd_sched #(.FIFO_DEPTH(DEPTH), .GAP_CYCLES(GAP), .ACK_TIMEOUT(ACK),
                    .REFRESH_CYCLES(REF)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
        .cmd_ready(cmd_ready), .spi_ready(spi_ready), .spi_start(spi_start),
        .spi_data(spi_data), .err_clr(err_clr), .err_timeout(err_timeout),
        .busy(busy), .fifo_level(fifo_level), .frames_sent(frames_sent));

    always #5 clk = ~clk;

    // Edge counter: after edge k (until the next one) edge_n == k.
    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    // Shift stage: samples spi_start, drops ready two edges later, shifts 16 bits MSB-first.
    int          ss_st = 0, ss_n = 0;
    logic [15:0] ss_sh = 16'd0, rx_sh = 16'd0, rx_word = 16'd0;
    logic        rx_done = 1'b0;
    always @(posedge clk) begin
        rx_done <= 1'b0;
        if (rst || tie_high) begin
            ss_st <= 0; spi_ready <= 1'b1; ss_n <= 0;
        end else begin
            case (ss_st)
                0: if (spi_start) begin ss_sh <= spi_data; ss_st <= 1; end
                1: ss_st <= 2;
                2: begin spi_ready <= 1'b0; ss_st <= 3; ss_n <= 0; end
                default: begin
                    rx_sh <= {rx_sh[14:0], ss_sh[15]};
                    ss_sh <= ss_sh << 1;
                    ss_n  <= ss_n + 1;
                    if (ss_n == 15) begin
                        spi_ready <= 1'b1; ss_st <= 0; rx_done <= 1'b1;
                        rx_word   <= {rx_sh[14:0], ss_sh[15]};
                    end
                end
            endcase
        end
    end

    // Scheduler model: queue of words plus timestamps of when the scheduler is free.
    logic [15:0] q[$];
    logic [15:0] m_data = 16'd0, m_last = 16'd0, m_frames = 16'd0;
    bit m_start = 0, m_err = 0, m_sent = 0, in_frame = 0, acked = 0, mvalid = 0;
    int start_e = 0, avail = 0;
    int rise_e[$], fall_e[$];
    logic [15:0] rise_w[$];
    logic prev_start = 1'b0;
    bit saw_full = 0;

    // Compare DUT to model each cycle, log frame starts, then advance the model one edge.
    always @(negedge clk) begin
        int e;
        bit rdy_pre, ab;
        if (mvalid) begin
            chk("fifo_level", fifo_level, q.size());
            chk("cmd_ready", cmd_ready, (q.size() != DEPTH));
            chk("spi_start", spi_start, m_start);
            chk("spi_data", spi_data, m_data);
            chk("frames_sent", frames_sent, m_frames);
            chk("err_timeout", err_timeout, m_err);
            chk("busy", busy, (in_frame || (edge_n < avail - 1)));
            if (rx_done) chk("mosi_word", rx_word, m_data);
            if (spi_start && !prev_start) begin rise_e.push_back(edge_n); rise_w.push_back(spi_data); end
            if (!spi_start && prev_start) fall_e.push_back(edge_n);
            if (fifo_level == 5'd4 && !cmd_ready) saw_full = 1;
        end
        prev_start = spi_start;
        e = edge_n + 1;
        if (rst) begin
            q.delete(); m_start = 0; m_data = 0; m_last = 0; m_frames = 0; m_err = 0;
            m_sent = 0; in_frame = 0; acked = 0; avail = e + 1; mvalid = 1;
        end else if (mvalid) begin
            rdy_pre = (q.size() != DEPTH);
            ab = 0;
            if (in_frame) begin
                if (!acked) begin
                    if (!spi_ready) begin acked = 1; m_start = 0; end
                    else if (e - start_e == int'(ACK)) begin
                        ab = 1; m_start = 0; in_frame = 0; m_err = 1; avail = e + int'(GAP) + 1;
                    end
                end else if (spi_ready) begin
                    m_frames++; m_sent = 1; in_frame = 0; avail = e + int'(GAP) + 1;
                end
            end else if (e >= avail) begin
                if (q.size() != 0) begin
                    m_data = q.pop_front(); m_last = m_data;
                    in_frame = 1; acked = 0; start_e = e; m_start = 1;
                end else if (REF != 0 && m_sent && e == avail - 1 + int'(REF)) begin
                    m_data = m_last;
                    in_frame = 1; acked = 0; start_e = e; m_start = 1;
                end
            end
            if (!ab && err_clr) m_err = 0;
            if (cmd_valid && rdy_pre) q.push_back(cmd_data);
        end
    end

    function automatic int re(int i); return (i >= 0 && i < rise_e.size()) ? rise_e[i] : -1; endfunction
    function automatic int fe(int i); return (i >= 0 && i < fall_e.size()) ? fall_e[i] : -1; endfunction
    function automatic int rw(int i); return (i >= 0 && i < rise_w.size()) ? int'(rise_w[i]) : -1; endfunction

    task automatic step(); @(posedge clk); #2; endtask

    task automatic wait_until_edge(input int k);
        while (edge_n < k) step();
    endtask

    task automatic wait_log(input int n, input int budget);
        for (int i = 0; i < budget && rise_e.size() < n; i++) step();
        chk("start_count", rise_e.size() >= n, 1);
    endtask

    task automatic do_reset();
        cmd_valid = 0; err_clr = 0; tie_high = 0;
        rst = 1; step(); step(); rst = 0;
        rise_e.delete(); rise_w.delete(); fall_e.delete();
    endtask

    task automatic push_word(input logic [15:0] w, input bit keep, output int acc);
        cmd_data = w; cmd_valid = 1; acc = -1;
        for (int i = 0; i < 1000; i++) begin
            if (cmd_ready) begin acc = edge_n + 1; step(); break; end
            step();
        end
        chk("push_accepted", acc >= 0, 1);
        if (!keep) cmd_valid = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int a, s, p;
        do_reset();
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_level", fifo_level, 0);
        chk("rst_start", spi_start, 0);
        chk("rst_data", spi_data, 0);

        // single word
        push_word(16'hA5C3, 0, a);
        chk("t1_level_after_accept", fifo_level, 1);
        step();
        chk("t1_start", spi_start, 1);
        chk("t1_level_after_pop", fifo_level, 0);
        wait_until_edge(a + 30);
        chk("t1_start_edge", re(0), a + 1);
        chk("t1_word", rw(0), 16'hA5C3);
        chk("t1_start_fall", fe(0) - re(0), 4);
        chk("t1_frames", frames_sent, 1);
        chk("t1_mosi", rx_word, 16'hA5C3);

        // burst of six words with valid held high
        do_reset();
        saw_full = 0;
        for (int w = 1; w <= 6; w++) push_word(16'(w), (w != 6), a);
        wait_log(6, 400);
        wait_until_edge(re(5) + 25);
        chk("t2_saw_full", saw_full, 1);
        for (int i = 0; i < 6; i++) chk("t2_order", rw(i), i + 1);
        for (int i = 1; i < 6; i++) chk("t2_spacing", re(i) - re(i - 1), 25);
        chk("t2_frames", frames_sent, 6);

        // refresh
        do_reset();
        push_word(16'h1234, 0, a);
        wait_log(3, 400);
        chk("t3_first", re(0), a + 1);
        chk("t3_period1", re(1) - re(0), 124);
        chk("t3_period2", re(2) - re(1), 124);
        chk("t3_w1", rw(1), 16'h1234);
        chk("t3_w2", rw(2), 16'h1234);
        p = re(2) + 70;
        wait_until_edge(p - 1);
        push_word(16'h5678, 0, a);
        chk("t3_new_acc", a, p);
        wait_log(5, 300);
        chk("t3_new_start", re(3), p + 1);
        chk("t3_new_word", rw(3), 16'h5678);
        chk("t3_restart", re(4) - re(3), 124);
        chk("t3_refresh_new", rw(4), 16'h5678);

        // acknowledge timeout
        do_reset();
        tie_high = 1;
        push_word(16'hBEEF, 0, a);
        s = a + 1;
        wait_until_edge(s + 40);
        chk("t4_rise", re(0), s);
        chk("t4_high_len", fe(0) - re(0), 32);
        chk("t4_err", err_timeout, 1);
        chk("t4_idle", busy, 0);
        err_clr = 1; step(); err_clr = 0;
        chk("t4_cleared", err_timeout, 0);
        push_word(16'hCAFE, 0, a);
        s = a + 1;
        wait_until_edge(s + 31);
        err_clr = 1; step(); err_clr = 0;
        chk("t4_set_wins", err_timeout, 1);
        step();
        chk("t4_still_set", err_timeout, 1);
        tie_high = 0;

        // reset during WAIT_DONE with three words queued
        do_reset();
        push_word(16'h0101, 1, a);
        s = a + 1;
        push_word(16'h0202, 1, p);
        push_word(16'h0303, 1, p);
        push_word(16'h0404, 0, p);
        wait_until_edge(s + 9);
        chk("t5_queued", fifo_level, 3);
        rst = 1; step(); rst = 0;
        chk("t5_start", spi_start, 0);
        chk("t5_level", fifo_level, 0);
        chk("t5_frames", frames_sent, 0);
        chk("t5_busy", busy, 0);
        push_word(16'h7777, 0, a);
        wait_until_edge(a + 30);
        chk("t5_next_edge", re(rise_e.size() - 1), a + 1);
        chk("t5_next_word", rw(rise_w.size() - 1), 16'h7777);
        chk("t5_next_frames", frames_sent, 1);

        // simultaneous push and pop at level 2
        do_reset();
        push_word(16'h0011, 0, a);
        s = a + 1;
        push_word(16'h0022, 0, p);
        push_word(16'h0033, 0, p);
        wait_until_edge(s + 24);
        chk("t6_level_before", fifo_level, 2);
        push_word(16'h0044, 0, a);
        chk("t6_acc_edge", a, s + 25);
        chk("t6_level_same", fifo_level, 2);
        wait_log(4, 200);
        wait_until_edge(re(3) + 25);
        chk("t6_w0", rw(0), 16'h0011);
        chk("t6_w1", rw(1), 16'h0022);
        chk("t6_w2", rw(2), 16'h0033);
        chk("t6_w3", rw(3), 16'h0044);
        chk("t6_frames", frames_sent, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
